// File: rtl/elevator_pkg.sv
// Shared elevator definitions: car state encoding, floor width and default plant timing.
package elevator_pkg;

  localparam int FLOOR_W           = 3;
  localparam int DEF_NUM_FLOORS    = 5;
  localparam int DEF_TRAVEL_CYCLES = 4;
  localparam int DEF_DOOR_CYCLES   = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR      = 2'd3
  } car_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/car_timer.sv
// Loadable up-counter over 0..LIMIT-1 with a terminal-count flag; wraps to 0 after terminal count.
module car_timer
  import elevator_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = cnt_w(LIMIT);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      r_count <= '0;
    else if (i_load || (i_en && o_tc)) r_count <= '0;
    else if (i_en)                  r_count <= r_count + 1'b1;
  end

  assign o_tc = (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/elevator_car_drive.sv
// Plant model of one elevator car: turns up/down/open commands into floor position,
// travel timing and door dwell, with registered status outputs for the controller.
module elevator_car_drive
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
  parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               up,
  input  logic               down,
  input  logic               open_req,
  output logic [FLOOR_W-1:0] floor,
  output logic               moving,
  output logic               dir_up,
  output logic               door_open,
  output logic               arrived,
  output logic               cmd_fault
);

  localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);

  car_state_e         r_state, w_state_nxt;
  logic [FLOOR_W-1:0] r_floor, w_floor_nxt;
  logic               r_moving, r_dir_up, r_door_open, r_arrived, r_cmd_fault;
  logic               w_arrive, w_fault, w_trav_load, w_door_load;
  logic               w_trav_tc, w_door_tc, w_in_move, w_in_door;
  logic               w_at_top, w_at_bot;
  logic [FLOOR_W-1:0] w_floor_up, w_floor_dn;

  assign w_in_move  = (r_state == ST_MOVE_UP) || (r_state == ST_MOVE_DOWN);
  assign w_in_door  = (r_state == ST_DOOR);
  assign w_at_top   = (r_floor == TOP);
  assign w_at_bot   = (r_floor == '0);
  assign w_floor_up = r_floor + 1'b1;
  assign w_floor_dn = r_floor - 1'b1;

  // Travel timer wraps on its own at each floor boundary, so continuing motion needs no reload.
  car_timer #(.LIMIT(TRAVEL_CYCLES)) u_travel (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_trav_load),
    .i_en   (w_in_move),
    .o_tc   (w_trav_tc)
  );

  car_timer #(.LIMIT(DOOR_CYCLES)) u_door (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_door_load),
    .i_en   (w_in_door),
    .o_tc   (w_door_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_floor_nxt = r_floor;
    w_arrive    = 1'b0;
    w_fault     = 1'b0;
    w_trav_load = 1'b0;
    w_door_load = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (up && down) begin
          w_fault = 1'b1;
        end else if (up && !w_at_top) begin
          w_state_nxt = ST_MOVE_UP;
          w_trav_load = 1'b1;
        end else if (down && !w_at_bot) begin
          w_state_nxt = ST_MOVE_DOWN;
          w_trav_load = 1'b1;
        end else if (open_req) begin
          w_state_nxt = ST_DOOR;
          w_door_load = 1'b1;
        end
      end
      ST_MOVE_UP: begin
        if (w_trav_tc) begin
          w_floor_nxt = w_floor_up;
          if (!(up && !down && (w_floor_up != TOP))) begin
            w_state_nxt = ST_DOOR;
            w_arrive    = 1'b1;
            w_door_load = 1'b1;
          end
        end
      end
      ST_MOVE_DOWN: begin
        if (w_trav_tc) begin
          w_floor_nxt = w_floor_dn;
          if (!(down && !up && (w_floor_dn != '0))) begin
            w_state_nxt = ST_DOOR;
            w_arrive    = 1'b1;
            w_door_load = 1'b1;
          end
        end
      end
      ST_DOOR: begin
        if (w_door_tc) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_floor     <= '0;
      r_moving    <= 1'b0;
      r_dir_up    <= 1'b0;
      r_door_open <= 1'b0;
      r_arrived   <= 1'b0;
      r_cmd_fault <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_floor     <= w_floor_nxt;
      r_moving    <= (w_state_nxt == ST_MOVE_UP) || (w_state_nxt == ST_MOVE_DOWN);
      r_dir_up    <= (w_state_nxt == ST_MOVE_UP);
      r_door_open <= (w_state_nxt == ST_DOOR);
      r_arrived   <= w_arrive;
      r_cmd_fault <= w_fault;
    end
  end

  assign floor     = r_floor;
  assign moving    = r_moving;
  assign dir_up    = r_dir_up;
  assign door_open = r_door_open;
  assign arrived   = r_arrived;
  assign cmd_fault = r_cmd_fault;

endmodule
